// File: rtl/heartbeat_scheduler_pkg.sv
// Shared types, default sizes and helpers for the heartbeat scheduler.
package heartbeat_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam int DEF_N_REQ         = 4;
    localparam int DEF_DATA_W        = 8;
    localparam int DEF_PREAMBLE_BITS = 4;
    localparam int DEF_GAP_CYCLES    = 4;
    localparam int DEF_HB_IDLE       = 64;
    localparam int HB_SRC_ID         = DEF_N_REQ;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/heartbeat_scheduler_if.sv
// Requester-side handshake bundle: per-requester req/data in, ack pulse back.
interface heartbeat_scheduler_if #(
    parameter int N_REQ  = heartbeat_pkg::DEF_N_REQ,
    parameter int DATA_W = heartbeat_pkg::DEF_DATA_W
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] data;
    logic [N_REQ-1:0]        ack;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/heartbeat_scheduler_arbiter.sv
// Round-robin pick of the first requester at or above the pointer, wrapping.
module rr_arbiter
    import heartbeat_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int PW = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_en,
    output logic             grant_valid,
    output logic [PW-1:0]    grant_idx
);
    logic [PW-1:0] ptr;
    logic [PW-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PW'((int'(ptr) + i) % N_REQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_en && grant_valid) begin
            ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/heartbeat_scheduler.sv
// Arbitrates status words onto one Manchester line; fills idle time with
// counter-carrying heartbeat frames so the pad never goes quiet.
module heartbeat_scheduler
    import heartbeat_pkg::*;
#(
    parameter int N_REQ         = DEF_N_REQ,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int PREAMBLE_BITS = DEF_PREAMBLE_BITS,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int HB_IDLE       = DEF_HB_IDLE,
    localparam int ID_W = clog2(N_REQ + 1)
) (
`ifdef USE_POWER_PINS
    inout  wire                  VSS,
    inout  wire                  VDD,
`endif
    input  logic                 clk,
    input  logic                 rst,
    heartbeat_scheduler_if.slave bus,
    output logic                 busy,
    output logic [ID_W-1:0]      src,
    output logic                 signal
);
    localparam int PW = (N_REQ > 1) ? clog2(N_REQ) : 1;
    localparam int F  = PREAMBLE_BITS + ID_W + DATA_W;
    localparam int BW = (F > 1) ? clog2(F) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? clog2(GAP_CYCLES) : 1;
    localparam int TW = (HB_IDLE > 1) ? clog2(HB_IDLE) : 1;
    localparam logic [BW-1:0]   LAST_BIT = BW'(F - 1);
    localparam logic [GW-1:0]   LAST_GAP = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]   TMR_END  = TW'(HB_IDLE - 1);
    localparam logic [ID_W-1:0] HB_ID    = ID_W'(N_REQ);

    state_t            state;
    logic [F-1:0]      shreg;
    logic              phase;
    logic              is_hb;
    logic [BW-1:0]     bit_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [TW-1:0]     idle_tmr;
    logic [DATA_W-1:0] hb_cnt;
    logic [N_REQ-1:0]  ack;
    logic              grant_valid;
    logic [PW-1:0]     grant_idx;
    logic              grant_en;
    logic [DATA_W-1:0] grant_data;

    assign bus.ack    = ack;
    assign grant_en   = (state == IDLE);
    assign grant_data = bus.data[int'(grant_idx)*DATA_W +: DATA_W];

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (bus.req),
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            phase    <= 1'b0;
            is_hb    <= 1'b0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            idle_tmr <= '0;
            hb_cnt   <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            src      <= '0;
            signal   <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    signal  <= 1'b0;
                    phase   <= 1'b0;
                    bit_cnt <= '0;
                    // A pending request always beats an expiring idle timer.
                    if (grant_valid) begin
                        ack[grant_idx] <= 1'b1;
                        src      <= ID_W'(grant_idx);
                        busy     <= 1'b1;
                        is_hb    <= 1'b0;
                        shreg    <= {{PREAMBLE_BITS{1'b1}}, ID_W'(grant_idx), grant_data};
                        idle_tmr <= '0;
                        state    <= SEND;
                    end else if (idle_tmr == TMR_END) begin
                        src      <= HB_ID;
                        busy     <= 1'b1;
                        is_hb    <= 1'b1;
                        shreg    <= {{PREAMBLE_BITS{1'b1}}, HB_ID, hb_cnt};
                        idle_tmr <= '0;
                        state    <= SEND;
                    end else begin
                        idle_tmr <= idle_tmr + 1'b1;
                    end
                end
                SEND: begin
                    signal <= shreg[F-1] ^ phase;
                    phase  <= ~phase;
                    if (phase) begin
                        shreg <= {shreg[F-2:0], 1'b0};
                        if (bit_cnt == LAST_BIT) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                            if (is_hb) hb_cnt <= hb_cnt + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    signal <= 1'b0;
                    if (gap_cnt == LAST_GAP) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        is_hb <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heartbeat_scheduler.sv
// Directed bench for heartbeat_scheduler: arbitration, framing, heartbeats, reset.
module tb_heartbeat_scheduler;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int ID_W   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            busy;
    logic [ID_W-1:0] src;
    logic            signal;
    int              checks = 0;
    int              failures = 0;

    heartbeat_scheduler_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

`ifdef USE_POWER_PINS
    wire VSS;
    wire VDD;
`endif

    heartbeat_scheduler #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .PREAMBLE_BITS(4),
        .GAP_CYCLES(4), .HB_IDLE(64)
    ) dut (
`ifdef USE_POWER_PINS
        .VSS(VSS), .VDD(VDD),
`endif
        .clk(clk), .rst(rst), .bus(bus),
        .busy(busy), .src(src), .signal(signal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] manch(input logic [2:0] id, input logic [7:0] pay);
        logic [14:0] f;
        logic [29:0] m;
        f = {4'b1111, id, pay};
        m = '0;
        for (int i = 0; i < 15; i++) begin
            m[2*i+1] = f[i];
            m[2*i]   = ~f[i];
        end
        return m;
    endfunction

    task automatic do_reset();
        bus.req = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.ack === '0 && waited < limit);
    endtask

    task automatic wait_busy(input logic level, input int limit, output int waited);
        waited = 0;
        while (busy !== level && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic grab(output logic [29:0] s, output logic ack_seen);
        ack_seen = 1'b0;
        s = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            s[29-i] = signal;
            if (bus.ack !== '0) ack_seen = 1'b1;
        end
    endtask

    initial begin
        logic [29:0] fr;
        logic        aseen;
        int          w;
        int          order [5];

        bus.req  = '0;
        bus.data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_signal", 32'(signal), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_src", 32'(src), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        rst = 1'b0;

        // single request from requester 2
        bus.data[23:16] = 8'hA5;
        bus.req = 4'b0100;
        wait_ack(10, w);
        chk("t1_ack_latency", 32'(w), 32'd1);
        chk("t1_ack", 32'(bus.ack), 32'h4);
        chk("t1_src", 32'(src), 32'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        bus.req = '0;
        grab(fr, aseen);
        chk("t1_frame", 32'(fr), 32'(30'b10_10_10_10_01_10_01_10_01_10_01_01_10_01_10));
        chk("t1_ack_once", 32'(aseen), 32'd0);
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            chk("t1_gap_signal", 32'(signal), 32'd0);
            chk("t1_gap_busy", 32'(busy), (g < 3) ? 32'd1 : 32'd0);
        end

        // all four requesting continuously
        do_reset();
        bus.data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req = 4'hF;
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            wait_ack(60, w);
            chk("t2_grant", 32'(bus.ack), 32'(1) << order[k]);
            chk("t2_spacing", 32'(w), (k == 0) ? 32'd1 : 32'd35);
        end
        bus.req = '0;

        // heartbeat after 64 idle clocks, counter increments and wraps
        do_reset();
        wait_busy(1'b1, 200, w);
        chk("t3_hb_delay", 32'(w), 32'd64);
        chk("t3_hb_src", 32'(src), 32'd4);
        chk("t3_hb_no_ack", 32'(bus.ack), 32'd0);
        grab(fr, aseen);
        chk("t3_hb0_frame", 32'(fr), 32'(manch(3'd4, 8'h00)));
        wait_busy(1'b0, 100, w);
        wait_busy(1'b1, 200, w);
        chk("t3_hb1_delay", 32'(w), 32'd64);
        grab(fr, aseen);
        chk("t3_hb1_frame", 32'(fr), 32'(manch(3'd4, 8'h01)));
        for (int k = 2; k <= 256; k++) begin
            wait_busy(1'b0, 100, w);
            wait_busy(1'b1, 200, w);
            grab(fr, aseen);
            if (k == 255) chk("t3_hb255_frame", 32'(fr), 32'(manch(3'd4, 8'hFF)));
            if (k == 256) chk("t3_hb256_wrap", 32'(fr), 32'(manch(3'd4, 8'h00)));
        end

        // request coincides with timer expiry
        do_reset();
        repeat (63) @(negedge clk);
        chk("t4_no_hb_yet", 32'(busy), 32'd0);
        bus.data[15:8] = 8'h3C;
        bus.req = 4'b0010;
        wait_ack(5, w);
        chk("t4_ack_latency", 32'(w), 32'd1);
        chk("t4_ack", 32'(bus.ack), 32'h2);
        chk("t4_src", 32'(src), 32'd1);
        bus.req = '0;
        grab(fr, aseen);
        chk("t4_frame", 32'(fr), 32'(manch(3'd1, 8'h3C)));
        wait_busy(1'b0, 100, w);
        wait_busy(1'b1, 200, w);
        chk("t4_timer_cleared", 32'(w), 32'd64);
        chk("t4_hb_src", 32'(src), 32'd4);
        grab(fr, aseen);
        chk("t4_hb_frame", 32'(fr), 32'(manch(3'd4, 8'h00)));

        // reset in mid-SEND
        do_reset();
        bus.data[15:8] = 8'h5A;
        bus.req = 4'b0010;
        wait_ack(5, w);
        chk("t5_first_ack", 32'(bus.ack), 32'h2);
        bus.req = '0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_signal", 32'(signal), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_src", 32'(src), 32'd0);
        rst = 1'b0;
        bus.data[7:0]   = 8'h0F;
        bus.data[31:24] = 8'hF0;
        bus.req = 4'b1001;
        wait_ack(5, w);
        chk("t5_ptr_reset_grant", 32'(bus.ack), 32'h1);
        bus.req = 4'b1000;
        wait_ack(60, w);
        chk("t5_second_grant", 32'(bus.ack), 32'h8);
        chk("t5_second_spacing", 32'(w), 32'd35);
        bus.req = '0;

        // withdrawn request during SEND
        do_reset();
        bus.req = 4'b0001;
        wait_ack(5, w);
        chk("t6_ack0", 32'(bus.ack), 32'h1);
        bus.req = '0;
        aseen = 1'b0;
        repeat (5) @(negedge clk);
        bus.req = 4'b0010;
        repeat (3) begin
            @(negedge clk);
            if (bus.ack !== '0) aseen = 1'b1;
        end
        bus.req = '0;
        w = 0;
        while (busy === 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
            if (bus.ack !== '0) aseen = 1'b1;
        end
        chk("t6_frame_done", 32'(busy), 32'd0);
        chk("t6_no_ack1", 32'(aseen), 32'd0);
        wait_busy(1'b1, 200, w);
        chk("t6_timer_from_zero", 32'(w), 32'd64);
        chk("t6_hb_src", 32'(src), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
